sched_delay_queue: RTL

SCHED_DELAY_QUEUE -- requirements
Module: sched_delay_queue

---
 rtl/sched_delay_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/sched_delay_queue.sv
// Delay-scheduling FIFO: each event waits in_delay extra cycles, then is released
// strictly in acceptance order through a registered valid/ready output stage.
module sched_delay_queue #(
    parameter int DW    = 32,
    parameter int TW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    input  logic [TW-1:0]                in_delay,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [TW-1:0]    r_cnt [DEPTH];
    logic [DEPTH-1:0] r_ripe;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_head_ripe_nxt;
    logic [DW-1:0]    w_head_data_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    // Next-state view of the head so the output stage can be registered.
    always_comb begin
        w_push       = in_valid && r_in_ready;
        w_pop        = r_out_valid && out_ready;
        w_rd_ptr_nxt = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
        // A slot becomes ripe one edge after its count has reached zero.
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_ripe_nxt = 1'b0;
            w_head_data_nxt = in_data;
        end else begin
            w_head_ripe_nxt = r_ripe[w_rd_ptr_nxt] | (r_cnt[w_rd_ptr_nxt] == '0);
            w_head_data_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Pointers, occupancy and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_wr_ptr    <= w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < CW'(DEPTH));
            r_out_valid <= (w_count_nxt != '0) && w_head_ripe_nxt;
            r_out_data  <= w_head_data_nxt;
        end
    end

    // Slot storage; every slot counts down every cycle, stalled or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ripe <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == AW'(i))) begin
                    r_mem[i]  <= in_data;
                    r_cnt[i]  <= in_delay;
                    r_ripe[i] <= 1'b0;
                end else if (r_cnt[i] == '0) begin
                    r_ripe[i] <= 1'b1;
                end else begin
                    r_cnt[i]  <= r_cnt[i] - TW'(1);
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign pending   = r_count;

endmodule
